imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
Inverse of the core's immediate decode path. It takes a 32-bit immediate value, an ImmSrc format code and a base instruction word. It scatters the immediate into the RISC-V instruction bit positions for that format and flags values the format cannot represent. It sits in the instruction-synthesis path (macro-op expander / self-test program generator) ahead of instruction memory writes, as a 2-stage valid/ready pipeline.

Parameters:
CNT_W, 16, width of saturating error counter ErrCount

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
InValid  in  1  input transaction valid
InReady  out  1  block can accept input this cycle
ImmSrc  in  3  format: 000 I, 001 U, 010 S, 011 B, 100 J; others illegal
ImmIn  in  32  immediate value (byte offset for B/J)
BaseInstr  in  32  instruction word supplying all non-immediate bits
OutValid  out  1  output transaction valid
OutReady  in  1  downstream accepts output this cycle
Instr  out  32  encoded instruction
ImmErr  out  1  immediate not representable, or illegal ImmSrc
ErrCount  out  CNT_W  count of output handshakes with ImmErr=1, saturating

Behaviour:
- Reset (async, rst_n=0): both stage valids=0, OutValid=0, Instr=0, ImmErr=0, ErrCount=0. InReady=1 once rst_n=1. Reset mid-transfer discards all in-flight data.
- Handshake: input accepted when InValid&InReady; output consumed when OutValid&OutReady. Data held stable while OutValid&!OutReady.
- Pipeline: S1 registers ImmSrc/ImmIn/BaseInstr. S2 registers encoded Instr and ImmErr. Accept-to-OutValid latency = 2 cycles. Throughput 1/cycle when OutReady=1.
- Stall: S2 loads when !S2valid | OutReady. S1 advances when S2 loads. InReady = !S1valid | S2 loads. InReady has no combinational dependence on InValid. Max 2 transactions buffered. Order preserved; no loss or duplication.
- Encoding: Instr[6:0]=BaseInstr[6:0] always. Bits not listed for the format come from BaseInstr.
  I: Instr[31:20]=ImmIn[11:0]; fit iff ImmIn[31:11] all equal.
  U: Instr[31:12]=ImmIn[31:12]; fit iff ImmIn[11:0]==0.
  S: Instr[31:25]=ImmIn[11:5], Instr[11:7]=ImmIn[4:0]; fit as I.
  B: Instr[31]=ImmIn[12], [7]=ImmIn[11], [30:25]=ImmIn[10:5], [11:8]=ImmIn[4:1]; fit iff ImmIn[31:12] all equal and ImmIn[0]==0.
  J: Instr[31]=ImmIn[20], [19:12]=ImmIn[19:12], [20]=ImmIn[11], [30:21]=ImmIn[10:1]; fit iff ImmIn[31:20] all equal and ImmIn[0]==0.
  Illegal ImmSrc (101-111): Instr=BaseInstr, ImmErr=1.
- ImmErr = !fit. The encoding is still produced from the truncated bits.
- Invariant: when ImmErr=0, sign-extend decode of Instr with the same ImmSrc returns exactly ImmIn.
- ErrCount increments by 1 on each output handshake with ImmErr=1. It holds at all-ones and never wraps. It does not increment while stalled.

Test Plan:
- I: ImmSrc=000, ImmIn=0xFFFFF800, BaseInstr=0x00000013 -> 2 cycles later Instr=0x80000013, ImmErr=0. ImmIn=0x00000800 -> Instr=0x80000013, ImmErr=1, ErrCount=1.
- B: ImmSrc=011, ImmIn=0xFFFFFFFC, BaseInstr=0x00000063 -> Instr=0xFE000EE3, ImmErr=0. ImmIn=0x00000003 -> ImmErr=1.
- J/U: ImmSrc=100, ImmIn=0x00000008, BaseInstr=0x0000006F -> 0x0080006F. ImmSrc=001, ImmIn=0x12345000, BaseInstr=0x00000037 -> 0x12345037, ImmErr=0. ImmIn=0x12345001 -> ImmErr=1.
- Backpressure: OutReady=0 for 5 cycles with InValid=1 and 3 distinct inputs -> exactly 2 accepted, InReady=0 after the 2nd. On OutReady=1, outputs appear in order, each once, back-to-back.
- Illegal ImmSrc=111, BaseInstr=0xDEADBEEF -> Instr=0xDEADBEEF, ImmErr=1. Force ErrCount to all-ones, then one more error -> stays all-ones.
- Reset mid-operation: rst_n=0 asynchronously with both stages full -> OutValid=0 and ErrCount=0 immediately, without waiting for a clock edge. After release, no stale output appears.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: scatters a 32-bit immediate into the RISC-V instruction bit
// positions for the selected format, merges it with a base instruction word
// and flags immediates the format cannot represent. Two-stage valid/ready
// pipeline: S1 captures the request, S2 holds the encoded result.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [2:0]       ImmSrc,
    input  logic [31:0]      ImmIn,
    input  logic [31:0]      BaseInstr,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [31:0]      Instr,
    output logic             ImmErr,
    output logic [CNT_W-1:0] ErrCount
);

    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_U = 3'b001;
    localparam logic [2:0] SRC_S = 3'b010;
    localparam logic [2:0] SRC_B = 3'b011;
    localparam logic [2:0] SRC_J = 3'b100;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Stage 1 request registers
    logic        s1_valid_q;
    logic [2:0]  s1_src_q;
    logic [31:0] s1_imm_q;
    logic [31:0] s1_base_q;

    // Stage 2 result registers
    logic             s2_valid_q;
    logic [31:0]      instr_q;
    logic             imm_err_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;

    // Combinational encoder results
    logic [31:0] enc_instr_s;
    logic        enc_err_s;

    // Flow control
    logic s2_load_s;
    logic in_ready_s;

    // S2 may take a new entry when it is empty or its entry leaves this cycle;
    // InReady depends only on state and OutReady, never on InValid.
    always_comb begin
        s2_load_s  = (~s2_valid_q) | OutReady;
        in_ready_s = (~s1_valid_q) | s2_load_s;
    end

    // Scatter the immediate for the S1 format and decide representability.
    always_comb begin
        enc_instr_s = s1_base_q;
        enc_err_s   = 1'b0;
        case (s1_src_q)
            SRC_I: begin
                enc_instr_s[31:20] = s1_imm_q[11:0];
                enc_err_s          = (s1_imm_q[31:11] != {21{s1_imm_q[31]}});
            end
            SRC_U: begin
                enc_instr_s[31:12] = s1_imm_q[31:12];
                enc_err_s          = (s1_imm_q[11:0] != 12'h000);
            end
            SRC_S: begin
                enc_instr_s[31:25] = s1_imm_q[11:5];
                enc_instr_s[11:7]  = s1_imm_q[4:0];
                enc_err_s          = (s1_imm_q[31:11] != {21{s1_imm_q[31]}});
            end
            SRC_B: begin
                enc_instr_s[31]    = s1_imm_q[12];
                enc_instr_s[7]     = s1_imm_q[11];
                enc_instr_s[30:25] = s1_imm_q[10:5];
                enc_instr_s[11:8]  = s1_imm_q[4:1];
                enc_err_s          = (s1_imm_q[31:12] != {20{s1_imm_q[31]}}) |
                                     s1_imm_q[0];
            end
            SRC_J: begin
                enc_instr_s[31]    = s1_imm_q[20];
                enc_instr_s[19:12] = s1_imm_q[19:12];
                enc_instr_s[20]    = s1_imm_q[11];
                enc_instr_s[30:21] = s1_imm_q[10:1];
                enc_err_s          = (s1_imm_q[31:20] != {12{s1_imm_q[31]}}) |
                                     s1_imm_q[0];
            end
            default: begin
                // Illegal format: pass the base word through and flag it.
                enc_instr_s = s1_base_q;
                enc_err_s   = 1'b1;
            end
        endcase
    end

    // Error counter next state: count consumed erroneous outputs, saturate.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (s2_valid_q && OutReady && imm_err_q && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Stage 1 register: capture a request whenever the input side is ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_src_q   <= 3'b000;
            s1_imm_q   <= 32'h0000_0000;
            s1_base_q  <= 32'h0000_0000;
        end else if (in_ready_s) begin
            s1_valid_q <= InValid;
            if (InValid) begin
                s1_src_q  <= ImmSrc;
                s1_imm_q  <= ImmIn;
                s1_base_q <= BaseInstr;
            end
        end
    end

    // Stage 2 register: load the encoded result when S2 is free or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            instr_q    <= 32'h0000_0000;
            imm_err_q  <= 1'b0;
        end else if (s2_load_s) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                instr_q   <= enc_instr_s;
                imm_err_q <= enc_err_s;
            end
        end
    end

    // Saturating count of erroneous output handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= {CNT_W{1'b0}};
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign InReady  = in_ready_s;
    assign OutValid = s2_valid_q;
    assign Instr    = instr_q;
    assign ImmErr   = imm_err_q;
    assign ErrCount = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed testbench for imm_encoder with hand-computed expected encodings.
module tb_imm_encoder;

    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic          clk;
    logic          rst_n;
    logic          InValid;
    logic          InReady;
    logic [2:0]    ImmSrc;
    logic [31:0]   ImmIn;
    logic [31:0]   BaseInstr;
    logic          OutValid;
    logic          OutReady;
    logic [31:0]   Instr;
    logic          ImmErr;
    logic [CW-1:0] ErrCount;

    int vectors;
    int miscompares;
    logic [CW-1:0] exp_cnt;

    imm_encoder #(.CNT_W(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .InValid(InValid),
        .InReady(InReady),
        .ImmSrc(ImmSrc),
        .ImmIn(ImmIn),
        .BaseInstr(BaseInstr),
        .OutValid(OutValid),
        .OutReady(OutReady),
        .Instr(Instr),
        .ImmErr(ImmErr),
        .ErrCount(ErrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one transaction with OutReady=1 and wait (bounded) for OutValid.
    // lat counts falling edges from the drive edge; 2 means the nominal latency.
    task automatic xfer(input logic [2:0] src, input logic [31:0] imm,
                        input logic [31:0] base, output int lat);
        @(negedge clk);
        InValid = 1'b1; ImmSrc = src; ImmIn = imm; BaseInstr = base;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) InValid = 1'b0;
        end while (!OutValid && lat < 10);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        ImmSrc = 3'b000; ImmIn = 32'h0; BaseInstr = 32'h0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({OutValid, ImmErr, Instr, ErrCount} !== {1'b0, 1'b0, 32'h0, {CW{1'b0}}}) begin
            miscompares++;
            $display("FAIL reset_state: got OutValid=%b ImmErr=%b Instr=%h ErrCount=%0d, want 0/0/0/0",
                     OutValid, ImmErr, Instr, ErrCount);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (InReady !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_inready: got %b want 1", InReady);
        end
        exp_cnt = '0;
    endtask

    task automatic test_i_format();
        int lat;
        xfer(3'b000, 32'hFFFF_F800, 32'h0000_0013, lat);
        vectors++;
        if (lat !== 2 || Instr !== 32'h8000_0013 || ImmErr !== 1'b0) begin
            miscompares++;
            $display("FAIL i_fit: got lat=%0d Instr=%h ImmErr=%b want 2/80000013/0", lat, Instr, ImmErr);
        end
        xfer(3'b000, 32'h0000_0800, 32'h0000_0013, lat);
        vectors++;
        if (lat !== 2 || Instr !== 32'h8000_0013 || ImmErr !== 1'b1) begin
            miscompares++;
            $display("FAIL i_overflow: got lat=%0d Instr=%h ImmErr=%b want 2/80000013/1", lat, Instr, ImmErr);
        end
        @(negedge clk);
        exp_cnt = exp_cnt + 1'b1;
        vectors++;
        if (ErrCount !== exp_cnt) begin
            miscompares++;
            $display("FAIL i_errcount: got %0d want %0d", ErrCount, exp_cnt);
        end
        xfer(3'b000, 32'h0000_0005, 32'hFFFF_FFFF, lat);
        vectors++;
        if (Instr !== 32'h005F_FFFF || ImmErr !== 1'b0) begin
            miscompares++;
            $display("FAIL i_base_bits: got Instr=%h ImmErr=%b want 005fffff/0", Instr, ImmErr);
        end
    endtask

    task automatic test_s_b_format();
        int lat;
        xfer(3'b010, 32'hFFFF_FFF5, 32'h0000_0023, lat);
        vectors++;
        if (Instr !== 32'hFE00_0AA3 || ImmErr !== 1'b0) begin
            miscompares++;
            $display("FAIL s_fit: got Instr=%h ImmErr=%b want fe000aa3/0", Instr, ImmErr);
        end
        xfer(3'b011, 32'hFFFF_FFFC, 32'h0000_0063, lat);
        vectors++;
        if (Instr !== 32'hFE00_0EE3 || ImmErr !== 1'b0) begin
            miscompares++;
            $display("FAIL b_fit: got Instr=%h ImmErr=%b want fe000ee3/0", Instr, ImmErr);
        end
        xfer(3'b011, 32'h0000_0003, 32'h0000_0063, lat);
        vectors++;
        if (Instr !== 32'h0000_0163 || ImmErr !== 1'b1) begin
            miscompares++;
            $display("FAIL b_odd: got Instr=%h ImmErr=%b want 00000163/1", Instr, ImmErr);
        end
        @(negedge clk);
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic test_j_u_format();
        int lat;
        xfer(3'b100, 32'h0000_0008, 32'h0000_006F, lat);
        vectors++;
        if (Instr !== 32'h0080_006F || ImmErr !== 1'b0) begin
            miscompares++;
            $display("FAIL j_fit: got Instr=%h ImmErr=%b want 0080006f/0", Instr, ImmErr);
        end
        xfer(3'b001, 32'h1234_5000, 32'h0000_0037, lat);
        vectors++;
        if (Instr !== 32'h1234_5037 || ImmErr !== 1'b0) begin
            miscompares++;
            $display("FAIL u_fit: got Instr=%h ImmErr=%b want 12345037/0", Instr, ImmErr);
        end
        xfer(3'b001, 32'h1234_5001, 32'h0000_0037, lat);
        vectors++;
        if (Instr !== 32'h1234_5037 || ImmErr !== 1'b1) begin
            miscompares++;
            $display("FAIL u_lowbits: got Instr=%h ImmErr=%b want 12345037/1", Instr, ImmErr);
        end
        @(negedge clk);
        exp_cnt = exp_cnt + 1'b1;
        vectors++;
        if (ErrCount !== exp_cnt) begin
            miscompares++;
            $display("FAIL ju_errcount: got %0d want %0d", ErrCount, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] imms [3];
        logic        rdy;
        int          idx;
        imms[0] = 32'h0000_0001; imms[1] = 32'h0000_0002; imms[2] = 32'h0000_0003;
        idx = 0;
        @(negedge clk);
        OutReady = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            InValid = 1'b1; ImmSrc = 3'b000; ImmIn = imms[idx]; BaseInstr = 32'h0000_0013;
            rdy = InReady;
            @(posedge clk);
            if (rdy && idx < 2) idx++;
            else if (rdy) idx = 3;
        end
        @(negedge clk);
        InValid = 1'b0;
        vectors++;
        if (idx !== 2 || InReady !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_accept: got accepted=%0d InReady=%b want 2/0", idx, InReady);
        end
        OutReady = 1'b1;
        #1;
        vectors++;
        if (OutValid !== 1'b1 || Instr !== 32'h0010_0013) begin
            miscompares++;
            $display("FAIL bp_first: got OutValid=%b Instr=%h want 1/00100013", OutValid, Instr);
        end
        @(negedge clk);
        vectors++;
        if (OutValid !== 1'b1 || Instr !== 32'h0020_0013) begin
            miscompares++;
            $display("FAIL bp_second: got OutValid=%b Instr=%h want 1/00200013", OutValid, Instr);
        end
        @(negedge clk);
        vectors++;
        if (OutValid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_no_dup: got OutValid=%b want 0", OutValid);
        end
    endtask

    task automatic test_illegal_saturate();
        int lat;
        xfer(3'b111, 32'h0000_0000, 32'hDEAD_BEEF, lat);
        vectors++;
        if (Instr !== 32'hDEAD_BEEF || ImmErr !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_src: got Instr=%h ImmErr=%b want deadbeef/1", Instr, ImmErr);
        end
        @(negedge clk);
        exp_cnt = exp_cnt + 1'b1;
        while (exp_cnt != CMAX) begin
            xfer(3'b101, 32'h0000_0000, 32'h0000_0013, lat);
            @(negedge clk);
            exp_cnt = exp_cnt + 1'b1;
        end
        vectors++;
        if (ErrCount !== CMAX) begin
            miscompares++;
            $display("FAIL cnt_reach_max: got %0d want %0d", ErrCount, CMAX);
        end
        xfer(3'b110, 32'h0000_0000, 32'h0000_0013, lat);
        @(negedge clk);
        vectors++;
        if (ErrCount !== CMAX) begin
            miscompares++;
            $display("FAIL cnt_saturate: got %0d want %0d", ErrCount, CMAX);
        end
    endtask

    task automatic test_reset_midflight();
        bit stale;
        @(negedge clk);
        OutReady = 1'b0;
        InValid = 1'b1; ImmSrc = 3'b111; ImmIn = 32'h0; BaseInstr = 32'h1111_1111;
        @(negedge clk);
        BaseInstr = 32'h2222_2222;
        @(negedge clk);
        InValid = 1'b0;
        vectors++;
        if (OutValid !== 1'b1 || InReady !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_prefill: got OutValid=%b InReady=%b want 1/0", OutValid, InReady);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (OutValid !== 1'b0 || ErrCount !== {CW{1'b0}}) begin
            miscompares++;
            $display("FAIL rst_async: got OutValid=%b ErrCount=%0d want 0/0", OutValid, ErrCount);
        end
        @(negedge clk);
        rst_n = 1'b1;
        OutReady = 1'b1;
        stale = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (OutValid !== 1'b0) stale = 1'b1;
        end
        vectors++;
        if (stale !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_stale: got stale output seen=%b want 0", stale);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        exp_cnt = '0;
        test_reset();
        test_i_format();
        test_s_b_format();
        test_j_u_format();
        test_back_to_back();
        test_illegal_saturate();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
